// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder controller.
// Provides the controller state type, BCD digit constants and the bit
// positions inside the two-bit error flag returned with each result.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

    // Bit positions inside res_err
    localparam int ERR_IN_BIT  = 0;   // an operand digit was above 9
    localparam int ERR_ADD_BIT = 1;   // the shared adder returned a digit above 9

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational screen for illegal packed-BCD digits.
// Ports:
//   digits  - DIGITS packed 4-bit digits, digit 0 in bits [3:0]
//   any_bad - 1 when at least one digit is above 9
module bcd_digit_check
    import bcd_pkg::*;
#(
    parameter int DIGITS = 1
) (
    input  logic [BCD_DIGIT_W*DIGITS-1:0] digits,
    output logic                          any_bad
);

    // OR together a per-digit "greater than 9" test
    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            any_bad = any_bad | (digits[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX);
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial sequencer for adding two packed-BCD operands through one
// shared, external, combinational BCD digit adder, least-significant digit
// first, with the decimal carry rippled through an internal register.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   start_valid/start_ready  - operand handshake (a_bcd, b_bcd)
//   dig_a, dig_b, dig_cin    - operands presented to the shared digit adder
//   dig_sum, dig_cout        - shared digit adder result, sampled same cycle
//   res_valid/res_ready      - result handshake (res_sum, res_cout, res_err)
//   res_err                  - bit0: operand digit > 9, bit1: adder digit > 9
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_valid,
    output logic                          start_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a_bcd,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b_bcd,
    output logic [BCD_DIGIT_W-1:0]        dig_a,
    output logic [BCD_DIGIT_W-1:0]        dig_b,
    output logic                          dig_cin,
    input  logic [BCD_DIGIT_W-1:0]        dig_sum,
    input  logic                          dig_cout,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] res_sum,
    output logic                          res_cout,
    output logic [1:0]                    res_err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    state_e                          state_r;
    state_e                          state_next_s;
    logic [BCD_DIGIT_W*DIGITS-1:0]   a_r;
    logic [BCD_DIGIT_W*DIGITS-1:0]   b_r;
    logic                            carry_r;
    logic [IDX_W-1:0]                idx_r;
    logic                            accept_s;
    logic                            in_bad_s;
    logic                            sum_bad_s;
    logic                            last_s;
    logic [BCD_DIGIT_W-1:0]          a_dig_s;
    logic [BCD_DIGIT_W-1:0]          b_dig_s;

    // Operands are screened as they arrive, so the error path needs no adder cycles
    bcd_digit_check #(
        .DIGITS (2 * DIGITS)
    ) u_in_check (
        .digits  ({a_bcd, b_bcd}),
        .any_bad (in_bad_s)
    );

    // Screens whatever the shared adder returns for the current digit
    bcd_digit_check #(
        .DIGITS (1)
    ) u_sum_check (
        .digits  (dig_sum),
        .any_bad (sum_bad_s)
    );

    assign start_ready = (state_r == IDLE);
    assign accept_s    = start_valid && start_ready;
    assign last_s      = (idx_r == IDX_LAST);

    // Select the current digit of each latched operand
    always_comb begin
        a_dig_s = 4'd0;
        b_dig_s = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_r == IDX_W'(i)) begin
                a_dig_s = a_r[i*BCD_DIGIT_W +: BCD_DIGIT_W];
                b_dig_s = b_r[i*BCD_DIGIT_W +: BCD_DIGIT_W];
            end else begin
                a_dig_s = a_dig_s;
                b_dig_s = b_dig_s;
            end
        end
    end

    // Adder inputs are only driven while a digit is being computed
    always_comb begin
        if (state_r == ADD) begin
            dig_a   = a_dig_s;
            dig_b   = b_dig_s;
            dig_cin = carry_r;
        end else begin
            dig_a   = 4'd0;
            dig_b   = 4'd0;
            dig_cin = 1'b0;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = in_bad_s ? DONE : ADD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ADD: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ADD;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand latches, carry/index sequencing and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r       <= {(BCD_DIGIT_W*DIGITS){1'b0}};
            b_r       <= {(BCD_DIGIT_W*DIGITS){1'b0}};
            carry_r   <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            res_valid <= 1'b0;
            res_sum   <= {(BCD_DIGIT_W*DIGITS){1'b0}};
            res_cout  <= 1'b0;
            res_err   <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r      <= a_bcd;
                        b_r      <= b_bcd;
                        carry_r  <= 1'b0;
                        idx_r    <= {IDX_W{1'b0}};
                        res_sum  <= {(BCD_DIGIT_W*DIGITS){1'b0}};
                        res_cout <= 1'b0;
                        // An illegal operand skips the adder entirely
                        if (in_bad_s) begin
                            res_err   <= 2'b01;
                            res_valid <= 1'b1;
                        end else begin
                            res_err   <= 2'b00;
                            res_valid <= 1'b0;
                        end
                    end
                end
                ADD: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx_r == IDX_W'(i)) begin
                            res_sum[i*BCD_DIGIT_W +: BCD_DIGIT_W] <= dig_sum;
                        end
                    end
                    carry_r <= dig_cout;
                    // Sticky until the next accept; the sequence still runs to the end
                    if (sum_bad_s) begin
                        res_err[ERR_ADD_BIT] <= 1'b1;
                    end
                    if (last_s) begin
                        res_cout  <= dig_cout;
                        res_valid <= 1'b1;
                        idx_r     <= {IDX_W{1'b0}};
                    end else begin
                        idx_r <= idx_r + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (DIGITS=4) with a behavioural
// BCD digit adder that can be forced to return an illegal digit.
module tb_bcd_serial_add_ctrl;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a_bcd = '0;
    logic [W-1:0] b_bcd = '0;
    logic [3:0]   dig_a;
    logic [3:0]   dig_b;
    logic         dig_cin;
    logic [3:0]   dig_sum;
    logic         dig_cout;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic [1:0]   res_err;

    int total = 0;
    int bad   = 0;
    bit inj_now = 1'b0;
    int add_s;

    bcd_serial_add_ctrl #(.DIGITS(D)) dut (
        .clk (clk), .rst (rst),
        .start_valid (start_valid), .start_ready (start_ready),
        .a_bcd (a_bcd), .b_bcd (b_bcd),
        .dig_a (dig_a), .dig_b (dig_b), .dig_cin (dig_cin),
        .dig_sum (dig_sum), .dig_cout (dig_cout),
        .res_valid (res_valid), .res_ready (res_ready),
        .res_sum (res_sum), .res_cout (res_cout), .res_err (res_err)
    );

    always #5 clk = ~clk;

    // Shared digit adder: decimal add, optionally forced to an illegal digit
    always_comb begin
        add_s = int'(dig_a) + int'(dig_b) + int'(dig_cin);
        if (add_s > 9) begin
            dig_sum  = 4'(add_s - 10);
            dig_cout = 1'b1;
        end else begin
            dig_sum  = 4'(add_s);
            dig_cout = 1'b0;
        end
        if (inj_now) dig_sum = 4'hC;
    end

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Decimal carry into digit i: do the lower i digits overflow?
    function automatic bit cin_at(input int av, input int bv, input int i);
        int p = 10 ** i;
        return ((av % p) + (bv % p)) >= p;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < D; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL reset_start_ready got=%b exp=1", start_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        total++; if (res_sum !== 16'h0 || res_cout !== 1'b0 || res_err !== 2'b00) begin bad++;
            $display("FAIL reset_result got=%h/%b/%b exp=0/0/0", res_sum, res_cout, res_err); end
        total++; if (dig_a !== 4'd0 || dig_b !== 4'd0 || dig_cin !== 1'b0) begin bad++;
            $display("FAIL reset_dig got=%h/%h/%b exp=0/0/0", dig_a, dig_b, dig_cin); end
        step();
        rst = 1'b0;
        step();
    endtask

    // One complete valid operation with per-digit and result checks
    task automatic test_valid_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit inj, input string nm);
        int av = bcd2int(a);
        int bv = bcd2int(b);
        int s  = av + bv;
        logic [W-1:0] exp_sum = int2bcd(s % 10000);
        bit exp_cout = (s >= 10000);
        logic [1:0] exp_err = 2'b00;
        if (inj) begin
            exp_sum[7:4] = 4'hC;
            exp_err = 2'b10;
        end
        start_valid = 1'b1; a_bcd = a; b_bcd = b;
        total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL %s_ready got=%b exp=1", nm, start_ready); end
        step();
        start_valid = 1'b0; a_bcd = 16'($urandom); b_bcd = 16'($urandom);
        for (int i = 0; i < D; i++) begin
            inj_now = inj && (i == 1);
            total++;
            if (dig_a !== a[i*4 +: 4] || dig_b !== b[i*4 +: 4] || dig_cin !== cin_at(av, bv, i)) begin bad++;
                $display("FAIL %s_dig%0d got=%h/%h/%b exp=%h/%h/%b", nm, i, dig_a, dig_b, dig_cin,
                         a[i*4 +: 4], b[i*4 +: 4], cin_at(av, bv, i)); end
            total++; if (res_valid !== 1'b0 || start_ready !== 1'b0) begin bad++;
                $display("FAIL %s_busy%0d got valid=%b ready=%b exp=0/0", nm, i, res_valid, start_ready); end
            step();
        end
        inj_now = 1'b0;
        total++;
        if (res_valid !== 1'b1 || res_sum !== exp_sum || res_cout !== exp_cout || res_err !== exp_err) begin bad++;
            $display("FAIL %s_result got v=%b sum=%h c=%b e=%b exp v=1 sum=%h c=%b e=%b", nm,
                     res_valid, res_sum, res_cout, res_err, exp_sum, exp_cout, exp_err); end
        total++; if (dig_a !== 4'd0 || dig_cin !== 1'b0) begin bad++; $display("FAIL %s_dig_idle got=%h/%b exp=0/0", nm, dig_a, dig_cin); end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        total++; if (res_valid !== 1'b0 || start_ready !== 1'b1) begin bad++;
            $display("FAIL %s_handshake got valid=%b ready=%b exp=0/1", nm, res_valid, start_ready); end
    endtask

    task automatic test_invalid();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int n = 0; n < 5; n++) begin
            if (n == 0) begin
                a = 16'h12A4; b = 16'h0000;
            end else begin
                a = rand_bcd(); b = rand_bcd();
                if (n[0]) a[$urandom_range(0, D-1)*4 +: 4] = 4'($urandom_range(10, 15));
                else      b[$urandom_range(0, D-1)*4 +: 4] = 4'($urandom_range(10, 15));
            end
            start_valid = 1'b1; a_bcd = a; b_bcd = b;
            step();
            start_valid = 1'b0;
            for (int c = 0; c < 3; c++) begin
                total++;
                if (res_valid !== 1'b1 || res_err !== 2'b01 || res_sum !== 16'h0 || res_cout !== 1'b0) begin bad++;
                    $display("FAIL invalid%0d_c%0d got v=%b e=%b sum=%h c=%b exp v=1 e=01 sum=0 c=0",
                             n, c, res_valid, res_err, res_sum, res_cout); end
                total++; if (dig_a !== 4'd0 || dig_b !== 4'd0) begin bad++;
                    $display("FAIL invalid%0d_dig got=%h/%h exp=0/0", n, dig_a, dig_b); end
                step();
            end
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            total++; if (res_valid !== 1'b0 || start_ready !== 1'b1) begin bad++;
                $display("FAIL invalid%0d_hs got v=%b r=%b exp=0/1", n, res_valid, start_ready); end
        end
    endtask

    task automatic test_hold();
        start_valid = 1'b1; a_bcd = 16'h4321; b_bcd = 16'h1111;
        step();
        start_valid = 1'b0;
        for (int i = 0; i < D; i++) step();
        start_valid = 1'b1; a_bcd = 16'h1111; b_bcd = 16'h2222;
        for (int c = 0; c < 10; c++) begin
            total++;
            if (res_valid !== 1'b1 || res_sum !== int2bcd(5432) || res_err !== 2'b00 || start_ready !== 1'b0) begin bad++;
                $display("FAIL hold_c%0d got v=%b sum=%h e=%b r=%b exp v=1 sum=5432 e=00 r=0",
                         c, res_valid, res_sum, res_err, start_ready); end
            step();
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        total++; if (start_ready !== 1'b1 || res_valid !== 1'b0) begin bad++;
            $display("FAIL hold_release got r=%b v=%b exp=1/0", start_ready, res_valid); end
        step();
        start_valid = 1'b0;
        total++; if (start_ready !== 1'b0 || dig_a !== 4'd1 || dig_b !== 4'd2) begin bad++;
            $display("FAIL hold_next_accept got r=%b dig=%h/%h exp r=0 dig=1/2", start_ready, dig_a, dig_b); end
        for (int i = 0; i < D; i++) step();
        total++; if (res_valid !== 1'b1 || res_sum !== int2bcd(3333)) begin bad++;
            $display("FAIL hold_next_result got v=%b sum=%h exp v=1 sum=3333", res_valid, res_sum); end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        start_valid = 1'b1; a_bcd = 16'h1234; b_bcd = 16'h5678;
        step();
        start_valid = 1'b0;
        step();
        step();
        total++; if (dig_a !== 4'd2 || dig_cin !== 1'b1) begin bad++;
            $display("FAIL midrst_digit2 got=%h/%b exp=2/1", dig_a, dig_cin); end
        rst = 1'b1;
        #1;
        total++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0 || res_sum !== 16'h0 || res_err !== 2'b00 ||
            res_cout !== 1'b0 || dig_a !== 4'd0 || dig_b !== 4'd0 || dig_cin !== 1'b0) begin bad++;
            $display("FAIL midrst_clear got r=%b v=%b sum=%h e=%b c=%b dig=%h/%h/%b exp all 0 r=1",
                     start_ready, res_valid, res_sum, res_err, res_cout, dig_a, dig_b, dig_cin); end
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL midrst_novalid%0d got=%b exp=0", c, res_valid); end
            step();
        end
        test_valid_op(16'h1234, 16'h5678, 1'b0, "midrst_fresh");
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            test_valid_op(rand_bcd(), rand_bcd(), 1'b0, "rand");
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_valid_op(16'h1234, 16'h5678, 1'b0, "basic");
        test_valid_op(16'h9999, 16'h0001, 1'b0, "carry");
        test_valid_op(16'h9999, 16'h9999, 1'b0, "max");
        test_invalid();
        test_valid_op(16'h0011, 16'h0011, 1'b1, "adderr");
        test_valid_op(16'h0011, 16'h0011, 1'b0, "errclear");
        test_hold();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
